ram_rmw_ctrl: RTL and testbench

RAM_RMW_CTRL -- requirements
Module: ram_rmw_ctrl

---
 rtl/ram_rmw_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ram_rmw_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rmw_ctrl.sv
// Single-port RAM controller with byte-strobe read-modify-write.
// One transaction is in flight at a time. A partial-strobe write becomes
// a RAM read followed by a merged write. Out-of-range addresses never
// reach the RAM and return an error response.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request; accept cycle drives the first RAM access
// RD_WAIT | RAM read data valid: capture for a read, merge for a write
// RESP    | response presented, held until rsp_ready_i
module ram_rmw_ctrl #(
   parameter  int DATA_WIDTH = 128,
   parameter  int DEPTH      = 32,
   localparam int ADDR_WIDTH = $clog2(DEPTH),
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [STRB_WIDTH-1:0] req_strb_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } state_t;

   // One extra bit so DEPTH itself is representable for the range compare.
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   state_t                state_q;
   logic                  write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] strb_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;

   logic                  accept;
   logic                  req_oor;
   logic                  strb_full;
   logic                  strb_none;
   logic                  single_cycle;
   logic [DATA_WIDTH-1:0] merge_wdata;

   assign req_ready_o  = (state_q == IDLE) && !rst_i;
   assign accept       = req_valid_i && req_ready_o;
   assign req_oor      = {1'b0, req_addr_i} >= DEPTH_W;
   assign strb_full    = &req_strb_i;
   assign strb_none    = ~|req_strb_i;
   // Requests that need no RAM read data respond directly from the accept cycle.
   assign single_cycle = req_oor || (req_write_i && (strb_full || strb_none));

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_err_o    = rsp_err_q;
   assign rsp_rdata_o  = rsp_rdata_q;

   // Byte merge of latched write data over the old RAM contents.
   always_comb begin
      merge_wdata = ram_rdata_i;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (strb_q[i]) begin
            merge_wdata[i*8 +: 8] = wdata_q[i*8 +: 8];
         end
      end
   end

   // RAM port drive; gated by reset so an interrupted RMW never writes.
   always_comb begin
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = req_addr_i;
      ram_wdata_o = req_wdata_i;
      if (!rst_i) begin
         case (state_q)
            IDLE: begin
               if (accept && !req_oor) begin
                  if (!req_write_i) begin
                     ram_en_o = 1'b1;
                  end else if (strb_full) begin
                     ram_en_o = 1'b1;
                     ram_we_o = 1'b1;
                  end else if (!strb_none) begin
                     ram_en_o = 1'b1;
                  end
               end
            end
            RD_WAIT: begin
               ram_addr_o  = addr_q;
               ram_wdata_o = merge_wdata;
               if (write_q) begin
                  ram_en_o = 1'b1;
                  ram_we_o = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Transaction FSM with registered response outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         strb_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  write_q     <= req_write_i;
                  addr_q      <= req_addr_i;
                  wdata_q     <= req_wdata_i;
                  strb_q      <= req_strb_i;
                  rsp_err_q   <= req_oor;
                  rsp_rdata_q <= '0;
                  if (single_cycle) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     state_q <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (!write_q) begin
                  rsp_rdata_q <= ram_rdata_i;
               end
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Bench for ram_rmw_ctrl: behavioural RAM behind the DUT, directed table,
// hand sequences for backpressure and reset-during-RMW, then random traffic
// checked against a transaction-level memory model.
module tb_ram_rmw_ctrl;

   localparam int DW = 128;
   localparam int DP = 20;
   localparam int AW = 5;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_strb;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   logic [DW-1:0] mem     [0:DP-1];
   logic [DW-1:0] ref_mem [0:DP-1];

   int checks = 0;
   int failures = 0;
   int n_rd = 0;
   int n_wr = 0;
   int viol = 0;

   always #5 clk = ~clk;

   ram_rmw_ctrl #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_write_i(req_write), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_strb_i(req_strb),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
   );

   // Behavioural synchronous RAM, read data valid the cycle after en.
   always @(posedge clk) begin
      if (ram_en && int'(ram_addr) < DP) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            n_wr = n_wr + 1;
         end else begin
            ram_rdata <= mem[ram_addr];
            n_rd = n_rd + 1;
         end
      end
   end

   // Port-rule monitor.
   always @(negedge clk) begin
      if (ram_we && !ram_en) viol = viol + 1;
      if (rsp_valid && ram_en) viol = viol + 1;
      if (ram_en && int'(ram_addr) >= DP) viol = viol + 1;
      if (rst && (ram_en || ram_we)) viol = viol + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chkv(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input integer act, input integer exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Transaction-level model: expected response and RAM traffic, updates ref_mem.
   task automatic model(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, output logic [DW-1:0] e_rdata,
                        output logic e_err, output int e_lat, output int e_rd, output int e_wr);
      e_rdata = '0; e_err = 1'b0; e_lat = 1; e_rd = 0; e_wr = 0;
      if (int'(a) >= DP) begin
         e_err = 1'b1;
      end else if (!wr) begin
         e_rdata = ref_mem[a]; e_lat = 2; e_rd = 1;
      end else if (st == '0) begin
         e_lat = 1;
      end else if (st == '1) begin
         e_wr = 1; ref_mem[a] = wd;
      end else begin
         e_lat = 2; e_rd = 1; e_wr = 1;
         for (int b = 0; b < SW; b++)
            if (st[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
      end
   endtask

   task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input int hold,
                         output logic [DW-1:0] r_data, output logic r_err,
                         output int lat, output int nrd, output int nwr);
      int guard;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_strb = st;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 20) begin
         failures++;
         $display("FAIL accept_wait actual=timeout required=req_ready_o");
      end
      n_rd = 0; n_wr = 0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 10);
      r_data = rsp_rdata; r_err = rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chki("hold_valid", 32'(rsp_valid), 1);
         chkv("hold_rdata", rsp_rdata, r_data);
         chki("hold_err", 32'(rsp_err), 32'(r_err));
         chki("hold_req_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      nrd = n_rd; nwr = n_wr;
      @(negedge clk);
      chki("post_hs_req_ready", 32'(req_ready), 1);
      chki("post_hs_valid", 32'(rsp_valid), 0);
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [SW-1:0] st;
      logic          e_err;
      int            e_lat;
      logic [DW-1:0] e_rdata;
      int            e_rd;
      int            e_wr;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [DW-1:0] r_data, m_rdata;
      logic          r_err, m_err;
      int            lat, nrd, nwr, m_lat, m_rd, m_wr, hold, sel;
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [SW-1:0] st;

      for (int i = 0; i < DP; i++) begin
         mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
         ref_mem[i] = mem[i];
      end
      mem[5] = {16{8'h11}};  ref_mem[5] = mem[5];
      mem[19] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; ref_mem[19] = mem[19];
      ram_rdata = '0;

      tbl[0] = '{1'b1, 5'd3,  {16{8'hAA}}, 16'hFFFF, 1'b0, 1, '0, 0, 1};
      tbl[1] = '{1'b0, 5'd3,  '0,          16'h0000, 1'b0, 2, {16{8'hAA}}, 1, 0};
      tbl[2] = '{1'b1, 5'd5,  {16{8'hFF}}, 16'h0003, 1'b0, 2, '0, 1, 1};
      tbl[3] = '{1'b0, 5'd5,  '0,          16'h0000, 1'b0, 2, {{14{8'h11}}, 16'hFFFF}, 1, 0};
      tbl[4] = '{1'b1, 5'd7,  {16{8'h5C}}, 16'h0000, 1'b0, 1, '0, 0, 0};
      tbl[5] = '{1'b0, 5'd25, '0,          16'h0000, 1'b1, 1, '0, 0, 0};
      tbl[6] = '{1'b1, 5'd31, {16{8'h77}}, 16'hFFFF, 1'b1, 1, '0, 0, 0};
      tbl[7] = '{1'b0, 5'd19, '0,          16'h0000, 1'b0, 2,
                 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1, 0};

      // Reset with a request already pending: RAM port must stay quiet.
      rst = 1'b1; rsp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chki("rst_req_ready", 32'(req_ready), 0);
      chki("rst_ram_en", 32'(ram_en), 0);
      chki("rst_ram_we", 32'(ram_we), 0);
      @(posedge clk);
      #1 rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chki("init_rsp_valid", 32'(rsp_valid), 0);
      chkv("init_rsp_rdata", rsp_rdata, '0);
      chki("init_rsp_err", 32'(rsp_err), 0);
      chki("init_req_ready", 32'(req_ready), 1);

      // Directed table.
      for (int v = 0; v < 8; v++) begin
         model(tbl[v].wr, tbl[v].addr, tbl[v].wd, tbl[v].st, m_rdata, m_err, m_lat, m_rd, m_wr);
         do_txn(tbl[v].wr, tbl[v].addr, tbl[v].wd, tbl[v].st, 0, r_data, r_err, lat, nrd, nwr);
         chkv($sformatf("tbl%0d_rdata", v), r_data, tbl[v].e_rdata);
         chki($sformatf("tbl%0d_err", v), 32'(r_err), 32'(tbl[v].e_err));
         chki($sformatf("tbl%0d_lat", v), lat, tbl[v].e_lat);
         chki($sformatf("tbl%0d_ram_rd", v), nrd, tbl[v].e_rd);
         chki($sformatf("tbl%0d_ram_wr", v), nwr, tbl[v].e_wr);
      end
      chkv("entry5_merge", mem[5], {{14{8'h11}}, 16'hFFFF});
      chkv("entry7_unchanged", mem[7], ref_mem[7]);

      // Read response held under backpressure for several cycles.
      model(1'b0, 5'd3, '0, '0, m_rdata, m_err, m_lat, m_rd, m_wr);
      do_txn(1'b0, 5'd3, '0, '0, 4, r_data, r_err, lat, nrd, nwr);
      chkv("bp_rdata", r_data, {16{8'hAA}});
      chki("bp_lat", lat, 2);

      // Reset pulsed in RD_WAIT of a partial write to entry 2.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd2;
      req_wdata = {16{8'hE7}}; req_strb = 16'h00F0;
      chki("rmw_rst_ready", 32'(req_ready), 1);
      n_rd = 0; n_wr = 0;
      @(posedge clk);
      #1 req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chki("rmw_rst_ram_en", 32'(ram_en), 0);
      chki("rmw_rst_ram_we", 32'(ram_we), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chki("rmw_rst_rsp_valid", 32'(rsp_valid), 0);
      chki("rmw_rst_req_ready", 32'(req_ready), 1);
      chki("rmw_rst_ram_rd", n_rd, 1);
      chki("rmw_rst_ram_wr", n_wr, 0);
      chkv("rmw_rst_entry2", mem[2], ref_mem[2]);

      // Random traffic against the model.
      for (int t = 0; t < 80; t++) begin
         wr = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(DP, 31)) : 5'($urandom_range(0, DP - 1));
         wd = {$urandom(), $urandom(), $urandom(), $urandom()};
         sel = $urandom_range(0, 3);
         st = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom());
         hold = $urandom_range(0, 2);
         model(wr, a, wd, st, m_rdata, m_err, m_lat, m_rd, m_wr);
         do_txn(wr, a, wd, st, hold, r_data, r_err, lat, nrd, nwr);
         chkv("rnd_rdata", r_data, m_rdata);
         chki("rnd_err", 32'(r_err), 32'(m_err));
         chki("rnd_lat", lat, m_lat);
         chki("rnd_ram_rd", nrd, m_rd);
         chki("rnd_ram_wr", nwr, m_wr);
      end

      for (int i = 0; i < DP; i++)
         chkv($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);
      chki("port_rule_violations", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
